// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor. Computes diff = a - b - bin modulo
// 2^WIDTH one bit per clock, LSB first, with a single full-subtractor cell and a
// registered borrow. Area is traded for latency: one operation takes WIDTH
// clocks of processing plus one DONE cycle and one IDLE cycle.
//
// Ports:
//   clk    single clock, all state changes on the rising edge
//   rst    synchronous, active-high reset (aborts any operation in flight)
//   start  request, accepted only on a rising edge where ready=1
//   a      minuend, sampled on the accepting edge only
//   b      subtrahend, sampled on the accepting edge only
//   bin    borrow-in, sampled on the accepting edge only
//   ready  idle and able to accept start
//   busy   bits are being processed
//   done   one-cycle pulse, result outputs are valid
//   diff   a - b - bin modulo 2^WIDTH
//   bout   final borrow-out (1 means unsigned a < b + bin)
//   ovf    signed overflow of the subtraction
//   zero   diff == 0, independent of bout
//
// Result outputs hold from done until the next accepted start has finished;
// they do not change during the following RUN phase.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   // Bit counter only needs to reach WIDTH-1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q,  state_d;
   logic [WIDTH-1:0] a_sh_q,   a_sh_d;
   logic [WIDTH-1:0] b_sh_q,   b_sh_d;
   logic [WIDTH-1:0] res_sh_q, res_sh_d;
   logic             br_q,     br_d;
   logic [CW-1:0]    cnt_q,    cnt_d;
   logic             a_msb_q,  a_msb_d;
   logic             b_msb_q,  b_msb_d;
   logic [WIDTH-1:0] diff_q,   diff_d;
   logic             bout_q,   bout_d;
   logic             ovf_q,    ovf_d;
   logic             zero_q,   zero_d;

   logic             bit_diff;
   logic             br_next;
   logic [WIDTH-1:0] res_full;

   // The single full-subtractor cell working on the current LSBs, plus the
   // result word as it will look once this bit has been shifted in. On the
   // final RUN edge res_full already holds the complete difference, which lets
   // the flags be registered on the same edge as the state change to DONE.
   always_comb begin
      bit_diff = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
      br_next  = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
      res_full = {bit_diff, res_sh_q[WIDTH-1:1]};
   end

   // Next-state and datapath control. Every register holds by default; IDLE
   // loads the operands on an accepted start, RUN shifts one bit per edge and
   // captures the result and flags on the last bit, DONE lasts a single cycle.
   // The operand sign bits are captured at load time because the operand
   // shift registers no longer hold them when overflow is evaluated.
   always_comb begin
      state_d  = state_q;
      a_sh_d   = a_sh_q;
      b_sh_d   = b_sh_q;
      res_sh_d = res_sh_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      diff_d   = diff_q;
      bout_d   = bout_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d   = a;
               b_sh_d   = b;
               br_d     = bin;
               cnt_d    = '0;
               res_sh_d = '0;
               a_msb_d  = a[WIDTH-1];
               b_msb_d  = b[WIDTH-1];
               state_d  = RUN;
            end
         end

         RUN: begin
            a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
            b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
            res_sh_d = res_full;
            br_d     = br_next;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == LAST_BIT) begin
               state_d = DONE;
               diff_d  = res_full;
               bout_d  = br_next;
               ovf_d   = (a_msb_q != b_msb_q) && (res_full[WIDTH-1] != a_msb_q);
               zero_d  = (res_full == '0);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers. Reset clears everything, which also
   // discards any operation in progress without producing done.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         a_sh_q   <= '0;
         b_sh_q   <= '0;
         res_sh_q <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         a_msb_q  <= 1'b0;
         b_msb_q  <= 1'b0;
         diff_q   <= '0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sh_q   <= a_sh_d;
         b_sh_q   <= b_sh_d;
         res_sh_q <= res_sh_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         a_msb_q  <= a_msb_d;
         b_msb_q  <= b_msb_d;
         diff_q   <= diff_d;
         bout_q   <= bout_d;
         ovf_q    <= ovf_d;
         zero_q   <= zero_d;
      end
   end

   // Handshake outputs decode directly from the state register, so done is
   // high for exactly the one cycle spent in DONE.
   always_comb begin
      ready = (state_q == IDLE);
      busy  = (state_q == RUN);
      done  = (state_q == DONE);
      diff  = diff_q;
      bout  = bout_q;
      ovf   = ovf_q;
      zero  = zero_q;
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Scoreboard bench for serial_subtractor (WIDTH=8). Stimulus pushes the
// expected result and the accept cycle into a queue; an independent monitor
// pops and compares every time done is seen. Directed vectors carry
// hand-computed results; the held-start phase uses an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             ready;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             ovf;
   logic             zero;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             bout;
      logic             ovf;
      logic             zero;
      int               acc;
   } exp_t;

   exp_t sb[$];
   exp_t monEntry;

   int total      = 0;
   int bad        = 0;
   int cycleCount = 0;
   int doneCount  = 0;
   int pushCount  = 0;
   int prevAcc    = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .bin   (bin),
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .diff  (diff),
      .bout  (bout),
      .ovf   (ovf),
      .zero  (zero)
   );

   // Free-running clock and a cycle counter used to measure latency.
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   // Single comparison point: every check goes through here.
   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // Reference result from plain wide arithmetic.
   function automatic exp_t refModel(input logic [WIDTH-1:0] ra, input logic [WIDTH-1:0] rb,
                                     input logic rbin);
      exp_t       e;
      logic [WIDTH:0] full;
      full   = {1'b0, ra} - {1'b0, rb} - {{WIDTH{1'b0}}, rbin};
      e.diff = full[WIDTH-1:0];
      e.bout = full[WIDTH];
      e.ovf  = (ra[WIDTH-1] != rb[WIDTH-1]) && (full[WIDTH-1] != ra[WIDTH-1]);
      e.zero = (full[WIDTH-1:0] == '0);
      e.acc  = 0;
      return e;
   endfunction

   // Bounded wait (at a falling edge) for ready.
   task automatic waitReady();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (ready) return;
      end
      checkOutput("ready_timeout", 0, 1);
   endtask

   // Bounded wait for the scoreboard to drain.
   task automatic waitDrain();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (sb.size() == 0) return;
      end
      checkOutput("drain_timeout", sb.size(), 0);
      sb.delete();
   endtask

   // Issue one single-pulse operation with its hand-computed result.
   task automatic applyStimulus(input logic [WIDTH-1:0] sa, input logic [WIDTH-1:0] sb_,
                                input logic sbin, input logic [WIDTH-1:0] eDiff,
                                input logic eBout, input logic eOvf, input logic eZero);
      exp_t e;
      waitReady();
      a     = sa;
      b     = sb_;
      bin   = sbin;
      start = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      e.diff = eDiff;
      e.bout = eBout;
      e.ovf  = eOvf;
      e.zero = eZero;
      e.acc  = cycleCount;
      sb.push_back(e);
      pushCount++;
      checkOutput("busy_after_accept", busy, 1);
      checkOutput("ready_after_accept", ready, 0);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation,
   // including the accept-to-done latency of WIDTH cycles.
   always @(negedge clk) begin
      if (!rst && done) begin
         doneCount++;
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
         end else begin
            monEntry = sb.pop_front();
            checkOutput("diff", diff, monEntry.diff);
            checkOutput("bout", bout, monEntry.bout);
            checkOutput("ovf", ovf, monEntry.ovf);
            checkOutput("zero", zero, monEntry.zero);
            checkOutput("latency", cycleCount - monEntry.acc, WIDTH);
            checkOutput("busy_in_done", busy, 0);
         end
      end
   end

   initial begin
      exp_t e;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      bin   = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      checkOutput("rst_ready", ready, 1);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
      checkOutput("rst_diff", diff, 0);
      checkOutput("rst_flags", {bout, ovf, zero}, 0);

      // Basic subtraction, then results must hold across idle cycles
      $display("[TB] basic subtraction and hold");
      applyStimulus(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0);
      waitDrain();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checkOutput("hold_diff", diff, 8'h1E);
         checkOutput("hold_flags", {done, bout, ovf, zero}, 0);
      end

      // Borrow, zero and overflow corners
      $display("[TB] borrow, zero and overflow vectors");
      applyStimulus(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
      applyStimulus(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
      applyStimulus(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b0);
      applyStimulus(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b0);
      applyStimulus(8'h33, 8'h33, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0);
      waitDrain();

      // Start and operand changes during RUN are ignored; outputs keep the
      // previous result until this operation completes.
      $display("[TB] start ignored while running");
      applyStimulus(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      checkOutput("run_keeps_old_diff", diff, 8'hFF);
      checkOutput("run_keeps_old_bout", bout, 1);
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'h00;
      bin   = 1'b1;
      repeat (2) @(negedge clk);
      start = 1'b0;
      waitDrain();
      repeat (12) @(negedge clk);
      checkOutput("after_ignored_diff", diff, 8'h02);

      // Reset in the middle of an operation: no done, reset values restored
      $display("[TB] reset mid-operation");
      applyStimulus(8'hA5, 8'h11, 1'b0, 8'h94, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      pushCount--;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("midrst_ready", ready, 1);
      checkOutput("midrst_busy", busy, 0);
      checkOutput("midrst_done", done, 0);
      checkOutput("midrst_diff", diff, 0);
      checkOutput("midrst_flags", {bout, ovf, zero}, 0);
      repeat (15) @(negedge clk);
      applyStimulus(8'hC8, 8'h64, 1'b0, 8'h64, 1'b0, 1'b1, 1'b0);
      waitDrain();

      // start held high: one accept every WIDTH+2 cycles with random operands
      $display("[TB] back-to-back with start held high");
      for (int n = 0; n < 500; n++) begin
         waitReady();
         a     = WIDTH'($urandom);
         b     = WIDTH'($urandom);
         bin   = 1'($urandom);
         start = 1'b1;
         e     = refModel(a, b, bin);
         @(posedge clk);
         #1;
         e.acc = cycleCount;
         sb.push_back(e);
         pushCount++;
         if (n > 0) checkOutput("period", cycleCount - prevAcc, WIDTH + 2);
         prevAcc = cycleCount;
      end
      start = 1'b0;
      waitDrain();
      repeat (5) @(negedge clk);
      checkOutput("done_count", doneCount, pushCount);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
